// File: rtl/jtframe_dwnld_sdram.sv
// Maps the byte-wide ioctl download stream onto SDRAM bank/word/mask writes,
// buffering bytes in a small FIFO and diverting the PROM region to prom_we.
module jtframe_dwnld_sdram #(
    parameter logic [26:0] HEADER     = 27'd0,
    parameter logic [26:0] BA1_START  = 27'h1FFFFFF,
    parameter logic [26:0] BA2_START  = 27'h1FFFFFF,
    parameter logic [26:0] BA3_START  = 27'h1FFFFFF,
    parameter logic [26:0] PROM_START = 27'h1FFFFFF,
    parameter bit          SWAB       = 1'b0,
    parameter int          FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        prom_we,
    output logic        dwnld_busy,
    output logic        fifo_ovf
);
    localparam int DEPTH = 2**FIFO_AW;

    typedef struct packed {
        logic        prom;
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WR, PROM} state_t;

    state_t             st, nxt;
    entry_t             mem [DEPTH];
    entry_t             din, head, src;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   cnt;
    logic [26:0]        eff;
    logic [22:0]        off;
    logic [21:0]        poff;
    logic               accept, empty, full, take, pop, push, bypass, dl_q;

    assign accept = ioctl_wr && downloading && (ioctl_addr >= HEADER);
    assign empty  = (cnt == '0);
    assign full   = (cnt == DEPTH[FIFO_AW:0]);
    assign head   = mem[rd_ptr];

    always_comb begin
        eff      = ioctl_addr - HEADER;
        poff     = 22'(eff - PROM_START);
        din      = '0;
        if (eff >= BA3_START) begin
            din.ba = 2'd3;
            off    = 23'(eff - BA3_START);
        end else if (eff >= BA2_START) begin
            din.ba = 2'd2;
            off    = 23'(eff - BA2_START);
        end else if (eff >= BA1_START) begin
            din.ba = 2'd1;
            off    = 23'(eff - BA1_START);
        end else begin
            din.ba = 2'd0;
            off    = 23'(eff);
        end
        din.prom = (eff >= PROM_START);
        din.addr = din.prom ? poff : off[22:1];
        din.mask = (off[0] ^ SWAB) ? 2'b01 : 2'b10;
        din.data = ioctl_dout;
    end

    // An idle machine with an empty FIFO takes the incoming byte directly,
    // so the write request appears in the cycle right after the accept edge.
    assign src = empty ? din : head;

    always_comb begin
        nxt  = st;
        take = 1'b0;
        unique case (st)
            IDLE: if (!empty || accept) begin
                take = 1'b1;
                nxt  = src.prom ? PROM : WR;
            end
            WR:      if (prog_rdy) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign pop    = take && !empty;
    assign bypass = take && empty;
    assign push   = accept && !bypass && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            dl_q     <= 1'b0;
            fifo_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
            dl_q <= downloading;
            if (downloading && !dl_q)       fifo_ovf <= 1'b0;
            if (accept && !bypass && !push) fifo_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            prog_we   <= 1'b0;
            prom_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prog_ba   <= '0;
        end else begin
            st      <= nxt;
            prog_we <= (nxt == WR);
            prom_we <= (nxt == PROM);
            if (take) begin
                prog_addr <= src.addr;
                prog_data <= {src.data, src.data};
                prog_mask <= src.mask;
                prog_ba   <= src.ba;
            end
        end
    end

    // Gated by rst_n so busy drops together with the async reset.
    assign dwnld_busy = rst_n && (downloading || !empty || (st != IDLE));

endmodule

// File: tb/tb_jtframe_dwnld_sdram.sv
// Bench for jtframe_dwnld_sdram: two instances (plain, and HEADER=16/SWAB=1)
// checked every cycle against a queue model plus directed literal checks.
module tb_jtframe_dwnld_sdram;
    logic        clk = 1'b0, rst_n = 1'b0, downloading = 1'b0, ioctl_wr = 1'b0, prog_rdy = 1'b1;
    logic [26:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [21:0] p_addr [2];
    logic [15:0] p_data [2];
    logic [1:0]  p_mask [2], p_ba [2];
    logic        p_we [2], p_prom [2], busy [2], ovf [2];

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    jtframe_dwnld_sdram #(.HEADER(27'd0), .BA1_START(27'h80000), .PROM_START(27'h100000),
                          .SWAB(1'b0), .FIFO_AW(2)) u0 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .prog_addr(p_addr[0]),
        .prog_data(p_data[0]), .prog_mask(p_mask[0]), .prog_ba(p_ba[0]), .prog_we(p_we[0]),
        .prog_rdy(prog_rdy), .prom_we(p_prom[0]), .dwnld_busy(busy[0]), .fifo_ovf(ovf[0]));

    jtframe_dwnld_sdram #(.HEADER(27'd16), .BA1_START(27'h80000), .PROM_START(27'h100000),
                          .SWAB(1'b1), .FIFO_AW(2)) u1 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .prog_addr(p_addr[1]),
        .prog_data(p_data[1]), .prog_mask(p_mask[1]), .prog_ba(p_ba[1]), .prog_we(p_we[1]),
        .prog_rdy(prog_rdy), .prom_we(p_prom[1]), .dwnld_busy(busy[1]), .fifo_ovf(ovf[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic        prom;
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [15:0] data;
    } exp_t;

    function automatic logic [26:0] hdr(input int i);
        return (i == 0) ? 27'd0 : 27'd16;
    endfunction

    function automatic exp_t model(input int i, input logic [26:0] a, input logic [7:0] d);
        exp_t        e;
        logic [26:0] eff, off;
        e      = '0;
        e.data = {d, d};
        eff    = a - hdr(i);
        if (eff >= 27'h100000) begin
            e.prom = 1'b1;
            e.addr = 22'(eff - 27'h100000);
        end else begin
            if (eff >= 27'h80000) begin e.ba = 2'd1; off = eff - 27'h80000; end
            else                  begin e.ba = 2'd0; off = eff; end
            e.addr = 22'(off / 2);
            // instance 1 swaps bytes: odd offsets land in the low byte
            e.mask = ((off % 2) == ((i == 1) ? 27'd1 : 27'd0)) ? 2'b10 : 2'b01;
        end
        return e;
    endfunction

    exp_t mq [2][64];
    exp_t cur [2], pend_e [2];
    int   mh [2], mt [2], mcnt [2], starts [2];
    bit   movf [2], pend [2], prev_we [2], prev_prom [2];
    bit   pend_rise, dl_last;
    bit   pop;
    exp_t e;

    initial begin
        for (int i = 0; i < 2; i++) starts[i] = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mh[i] = 0; mt[i] = 0; mcnt[i] = 0; movf[i] = 0;
                pend[i] = 0; prev_we[i] = 0; prev_prom[i] = 0;
            end
            pend_rise = 0;
            dl_last   = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                pop = (p_we[i] && !prev_we[i]) || p_prom[i];
                if (pend_rise) movf[i] = 0;
                if (pend[i]) begin
                    if (mcnt[i] - (pop ? 1 : 0) < 4) begin
                        mq[i][mt[i] % 64] = pend_e[i];
                        mt[i]++;
                        mcnt[i]++;
                    end else movf[i] = 1;
                end
                if (pop) begin
                    starts[i]++;
                    chk("gap", 32'(prev_we[i] || prev_prom[i]), 0);
                    if (mcnt[i] == 0) chk("spurious_write", 1, 0);
                    else begin
                        e = mq[i][mh[i] % 64];
                        mh[i]++;
                        mcnt[i]--;
                        cur[i] = e;
                        chk("kind_prom", 32'(p_prom[i]), 32'(e.prom));
                        chk("kind_we", 32'(p_we[i]), 32'(!e.prom));
                        chk("addr", 32'(p_addr[i]), 32'(e.addr));
                        chk("data", 32'(p_data[i]), 32'(e.data));
                        if (!e.prom) begin
                            chk("ba", 32'(p_ba[i]), 32'(e.ba));
                            chk("mask", 32'(p_mask[i]), 32'(e.mask));
                        end
                    end
                end else if (p_we[i]) begin
                    chk("hold_addr", 32'(p_addr[i]), 32'(cur[i].addr));
                    chk("hold_data", 32'(p_data[i]), 32'(cur[i].data));
                    chk("hold_mask", 32'(p_mask[i]), 32'(cur[i].mask));
                    chk("hold_ba", 32'(p_ba[i]), 32'(cur[i].ba));
                end else if (!prev_we[i] && !prev_prom[i]) begin
                    chk("stall", 32'(mcnt[i] != 0), 0);
                end
                chk("ovf", 32'(ovf[i]), 32'(movf[i]));
                chk("busy", 32'(busy[i]), 32'(downloading || mcnt[i] != 0 || p_we[i] || p_prom[i]));
                prev_we[i]   = p_we[i];
                prev_prom[i] = p_prom[i];
                pend[i]      = ioctl_wr && downloading && (ioctl_addr >= hdr(i));
                pend_e[i]    = model(i, ioctl_addr, ioctl_dout);
            end
            pend_rise = downloading && !dl_last;
            dl_last   = downloading;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // back-to-back bytes; returns just after the edge that accepts the last one
    task automatic burst(input logic [26:0] a, input int n, input logic [7:0] d);
        for (int k = 0; k < n; k++) begin
            step();
            ioctl_wr   = 1'b1;
            ioctl_addr = a + 27'(k);
            ioctl_dout = d + 8'(k);
        end
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while ((busy[0] || busy[1]) && cyc < 200) begin
            step();
            cyc++;
        end
        chk(name, 32'(busy[0] || busy[1]), 0);
    endtask

    int s0;

    initial begin
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_we", 32'(p_we[i]), 0);
            chk("rst_prom", 32'(p_prom[i]), 0);
            chk("rst_ovf", 32'(ovf[i]), 0);
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_addr", 32'(p_addr[i]), 0);
            chk("rst_data", 32'(p_data[i]), 0);
            chk("rst_ba", 32'(p_ba[i]), 0);
            chk("rst_mask", 32'(p_mask[i]), 2'b11);
        end
        rst_n = 1'b1; downloading = 1'b1; prog_rdy = 1'b1;

        // bank 0 basic writes
        burst(27'd0, 1, 8'hA5);
        chk("t1_we", 32'(p_we[0]), 1);
        chk("t1_addr", 32'(p_addr[0]), 0);
        chk("t1_mask", 32'(p_mask[0]), 2'b10);
        chk("t1_data", 32'(p_data[0]), 16'hA5A5);
        chk("t1_ba", 32'(p_ba[0]), 0);
        chk("t1_hdr_skip", 32'(p_we[1]), 0);
        step();
        chk("t1_pulse", 32'(p_we[0]), 0);
        burst(27'd1, 1, 8'h5A);
        chk("t1b_we", 32'(p_we[0]), 1);
        chk("t1b_addr", 32'(p_addr[0]), 0);
        chk("t1b_mask", 32'(p_mask[0]), 2'b01);
        chk("t1b_data", 32'(p_data[0]), 16'h5A5A);
        repeat (4) step();

        // bank 1 and PROM decode
        burst(27'h80003, 1, 8'h11);
        chk("t2_we", 32'(p_we[0]), 1);
        chk("t2_ba", 32'(p_ba[0]), 1);
        chk("t2_addr", 32'(p_addr[0]), 1);
        chk("t2_mask", 32'(p_mask[0]), 2'b01);
        repeat (2) step();
        burst(27'h100005, 1, 8'h22);
        chk("t2_prom", 32'(p_prom[0]), 1);
        chk("t2_prom_addr", 32'(p_addr[0]), 5);
        chk("t2_prom_nowe", 32'(p_we[0]), 0);
        step();
        chk("t2_prom_pulse", 32'(p_prom[0]), 0);
        repeat (3) step();

        // header skip and byte swap on instance 1
        for (int a = 0; a < 16; a++) begin
            burst(27'(a), 1, 8'(8'h40 + a));
            chk("t3_hdr_skip", 32'(p_we[1]), 0);
        end
        burst(27'd16, 1, 8'h33);
        chk("t3_we", 32'(p_we[1]), 1);
        chk("t3_addr", 32'(p_addr[1]), 0);
        chk("t3_mask", 32'(p_mask[1]), 2'b01);
        chk("t3_data", 32'(p_data[1]), 16'h3333);
        repeat (4) step();

        // back-pressure: one write stuck in flight, then 5 more into a 4-deep FIFO
        prog_rdy = 1'b0;
        burst(27'h40, 1, 8'h80);
        burst(27'h41, 5, 8'h81);
        chk("t4_ovf0", 32'(ovf[0]), 1);
        chk("t4_ovf1", 32'(ovf[1]), 1);
        downloading = 1'b0;
        step();
        chk("t4_busy", 32'(busy[0]), 1);
        s0 = starts[0];
        prog_rdy = 1'b1;
        wait_idle("t4_drain_timeout");
        chk("t4_writes", 32'(starts[0] - s0), 4);
        chk("t4_last_addr", 32'(p_addr[0]), 22'h22);
        chk("t4_ovf_sticky", 32'(ovf[0]), 1);

        // drain after end of download, preceded by ovf clear on new download
        downloading = 1'b1;
        step();
        chk("t5_ovf_clr0", 32'(ovf[0]), 0);
        chk("t5_ovf_clr1", 32'(ovf[1]), 0);
        prog_rdy = 1'b0;
        s0 = starts[0];
        burst(27'h50, 3, 8'hC0);
        downloading = 1'b0;
        step();
        chk("t5_busy", 32'(busy[0]), 1);
        prog_rdy = 1'b1;
        wait_idle("t5_drain_timeout");
        chk("t5_writes", 32'(starts[0] - s0), 3);

        // reset in the middle of a held write
        downloading = 1'b1;
        prog_rdy = 1'b0;
        burst(27'h60, 3, 8'hD0);
        step();
        chk("t6_we_before", 32'(p_we[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("t6_we", 32'(p_we[i]), 0);
            chk("t6_mask", 32'(p_mask[i]), 2'b11);
            chk("t6_busy", 32'(busy[i]), 0);
        end
        step();
        rst_n = 1'b1;
        prog_rdy = 1'b1;
        downloading = 1'b0;
        s0 = starts[0];
        repeat (6) step();
        chk("t6_no_writes", 32'(starts[0] - s0), 0);
        chk("t6_empty0", 32'(busy[0]), 0);
        chk("t6_empty1", 32'(busy[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
